// File: rtl/ctrl_pipe.sv
// ctrl_pipe -- pipelined control unit for the five-stage MIPS core.
//
// The instruction in D is decoded once into a control word. The word moves
// through the D/E, E/M and M/W registers, and its tnew field counts down by
// one per stage, stopping at zero. The block also detects hazards from
// Tuse/Tnew, drives the D- and E-stage forwarding selects, and keeps the
// busy counter for the multiply/divide unit.
//
// Ports:
//   clk, reset_n             rising-edge clock, synchronous active-low reset
//   instr_d[31:0]            instruction held in D
//   stall                    hold PC and IF/ID, insert a bubble into E
//   ext_op_d, pc_sel_d       immediate-extension mode and next-PC source
//   fwd_rs_d, fwd_rt_d       compare-operand source in D (0 RF, 1 M, 2 W)
//   alu_op_e, alu_b_sel_e    ALU function and B-operand select in E
//   fwd_rs_e, fwd_rt_e       ALU-operand source in E (0 pipe reg, 1 M, 2 W)
//   md_start_e, md_busy      mult/div start pulse and unit-occupied flag
//   dm_we_m, dm_re_m         data-memory write/read in M
//   reg_we_w, wa_w, wd_sel_w register-file write enable, address and source in W
module ctrl_pipe #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] instr_d,
   output logic        stall,
   output logic [1:0]  ext_op_d,
   output logic [1:0]  pc_sel_d,
   output logic [1:0]  fwd_rs_d,
   output logic [1:0]  fwd_rt_d,
   output logic [3:0]  alu_op_e,
   output logic        alu_b_sel_e,
   output logic [1:0]  fwd_rs_e,
   output logic [1:0]  fwd_rt_e,
   output logic [1:0]  md_start_e,
   output logic        md_busy,
   output logic        dm_we_m,
   output logic        dm_re_m,
   output logic        reg_we_w,
   output logic [4:0]  wa_w,
   output logic [1:0]  wd_sel_w
);

   typedef enum logic [3:0] {
      ALU_ADD, ALU_ADDU, ALU_SUB, ALU_SUBU, ALU_SLL,
      ALU_SRL, ALU_AND, ALU_OR, ALU_XOR, ALU_LUI
   } alu_op_t;

   typedef enum logic [1:0] {MD_NONE, MD_MULT, MD_DIV} md_op_t;

   typedef struct packed {
      alu_op_t    alu_op;
      logic       alu_b_sel;
      md_op_t     md_op;
      logic       dm_we;
      logic       dm_re;
      logic       reg_we;
      logic [4:0] wa;
      logic [1:0] wd_sel;
      logic [1:0] tnew;
   } cw_t;

   localparam cw_t        CW_NOP    = '0;
   localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES);
   localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES);

   // One stage older: tnew counts down and stops at zero.
   function automatic cw_t age(input cw_t cw);
      age = cw;
      if (cw.tnew != 2'd0) age.tnew = cw.tnew - 2'd1;
   endfunction

   // True when register r is still being produced by the instruction in cw
   // and the consumer needs it sooner than it will be ready.
   function automatic logic pending(input cw_t cw, input logic [4:0] r, input logic [1:0] tuse);
      pending = (r != 5'd0) && cw.reg_we && (cw.wa == r) && (tuse < cw.tnew);
   endfunction

   // Nearest older stage holding a finished result for r: M first, then W.
   function automatic logic [1:0] fwd_from(input logic [4:0] r, input cw_t m, input cw_t w);
      if (r != 5'd0 && m.reg_we && m.wa == r && m.tnew == 2'd0)      fwd_from = 2'd1;
      else if (r != 5'd0 && w.reg_we && w.wa == r && w.tnew == 2'd0) fwd_from = 2'd2;
      else                                                          fwd_from = 2'd0;
   endfunction

   logic [5:0] op, funct;
   logic [4:0] rs, rt, rd;
   logic       unused_shamt;

   assign op           = instr_d[31:26];
   assign rs           = instr_d[25:21];
   assign rt           = instr_d[20:16];
   assign rd           = instr_d[15:11];
   assign funct        = instr_d[5:0];
   assign unused_shamt = ^instr_d[10:6];

   cw_t        cw_d, cw_e, cw_m, cw_w;
   logic [4:0] rs_e, rt_e;
   logic [4:0] md_count;
   logic       use_rs, use_rt, is_md, r_alu;
   logic [1:0] tuse_rs, tuse_rt;

   // ---------------------------------------------------------------- decode
   // NOTE: every signal written here gets a default first, so no path leaves
   // a variable unassigned and no latch is inferred.
   always_comb begin
      cw_d     = CW_NOP;
      ext_op_d = 2'd0;
      pc_sel_d = 2'd0;
      use_rs   = 1'b0;
      use_rt   = 1'b0;
      tuse_rs  = 2'd0;
      tuse_rt  = 2'd0;
      is_md    = 1'b0;
      r_alu    = 1'b0;
      case (op)
         6'h00: begin
            case (funct)
               6'h20: begin r_alu = 1'b1; cw_d.alu_op = ALU_ADD;  end
               6'h21: begin r_alu = 1'b1; cw_d.alu_op = ALU_ADDU; end
               6'h22: begin r_alu = 1'b1; cw_d.alu_op = ALU_SUB;  end
               6'h23: begin r_alu = 1'b1; cw_d.alu_op = ALU_SUBU; end
               6'h00: begin r_alu = 1'b1; cw_d.alu_op = ALU_SLL;  end
               6'h02: begin r_alu = 1'b1; cw_d.alu_op = ALU_SRL;  end
               6'h24: begin r_alu = 1'b1; cw_d.alu_op = ALU_AND;  end
               6'h25: begin r_alu = 1'b1; cw_d.alu_op = ALU_OR;   end
               6'h26: begin r_alu = 1'b1; cw_d.alu_op = ALU_XOR;  end
               6'h08: begin pc_sel_d = 2'd2; use_rs = 1'b1; end
               6'h18, 6'h1a: begin
                  cw_d.md_op = (funct == 6'h18) ? MD_MULT : MD_DIV;
                  is_md  = 1'b1;
                  use_rs = 1'b1; tuse_rs = 2'd1;
                  use_rt = 1'b1; tuse_rt = 2'd1;
               end
               6'h10, 6'h12: begin
                  is_md = 1'b1;
                  cw_d.reg_we = 1'b1; cw_d.wa = rd; cw_d.tnew = 2'd2;
               end
               6'h11, 6'h13: begin is_md = 1'b1; use_rs = 1'b1; tuse_rs = 2'd1; end
               default: ;
            endcase
            if (r_alu) begin
               cw_d.reg_we = 1'b1; cw_d.wa = rd; cw_d.tnew = 2'd2;
               // Shifts take their amount from shamt, so rs is not a source.
               use_rs  = (funct != 6'h00) && (funct != 6'h02);
               tuse_rs = 2'd1;
               use_rt  = 1'b1; tuse_rt = 2'd1;
            end
         end
         6'h0d, 6'h08, 6'h09: begin
            cw_d.alu_op = (op == 6'h0d) ? ALU_OR : (op == 6'h08) ? ALU_ADD : ALU_ADDU;
            ext_op_d    = (op == 6'h0d) ? 2'd0 : 2'd1;
            cw_d.alu_b_sel = 1'b1;
            cw_d.reg_we = 1'b1; cw_d.wa = rt; cw_d.tnew = 2'd2;
            use_rs = 1'b1; tuse_rs = 2'd1;
         end
         6'h0f: begin
            cw_d.alu_op = ALU_LUI; cw_d.alu_b_sel = 1'b1; ext_op_d = 2'd2;
            cw_d.reg_we = 1'b1; cw_d.wa = rt; cw_d.tnew = 2'd2;
         end
         6'h23: begin
            cw_d.alu_op = ALU_ADDU; cw_d.alu_b_sel = 1'b1; ext_op_d = 2'd1;
            cw_d.dm_re  = 1'b1; cw_d.wd_sel = 2'd1;
            cw_d.reg_we = 1'b1; cw_d.wa = rt; cw_d.tnew = 2'd3;
            use_rs = 1'b1; tuse_rs = 2'd1;
         end
         6'h2b: begin
            cw_d.alu_op = ALU_ADDU; cw_d.alu_b_sel = 1'b1; ext_op_d = 2'd1;
            cw_d.dm_we = 1'b1;
            // Store data is needed only in M, one stage later than the address.
            use_rs = 1'b1; tuse_rs = 2'd1;
            use_rt = 1'b1; tuse_rt = 2'd2;
         end
         6'h04, 6'h05: begin
            ext_op_d = 2'd1; pc_sel_d = 2'd1;
            use_rs = 1'b1; use_rt = 1'b1;
         end
         6'h02: pc_sel_d = 2'd1;
         6'h03: begin
            pc_sel_d = 2'd1;
            cw_d.reg_we = 1'b1; cw_d.wa = 5'd31; cw_d.wd_sel = 2'd2; cw_d.tnew = 2'd1;
         end
         default: ;
      endcase
      // $0 is hard-wired, so a write to it is dropped here and never forwarded.
      if (cw_d.wa == 5'd0) cw_d.reg_we = 1'b0;
   end

   // ---------------------------------------------------------------- hazards
   assign stall = (use_rs && (pending(cw_e, rs, tuse_rs) || pending(cw_m, rs, tuse_rs)))
                || (use_rt && (pending(cw_e, rt, tuse_rt) || pending(cw_m, rt, tuse_rt)))
                || (is_md && (md_busy || cw_e.md_op != MD_NONE));

   assign fwd_rs_d = fwd_from(rs,   cw_m, cw_w);
   assign fwd_rt_d = fwd_from(rt,   cw_m, cw_w);
   assign fwd_rs_e = fwd_from(rs_e, cw_m, cw_w);
   assign fwd_rt_e = fwd_from(rt_e, cw_m, cw_w);

   // ---------------------------------------------------------- stage registers
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the values from before the edge, whatever the statement order.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cw_e <= CW_NOP;
         cw_m <= CW_NOP;
         cw_w <= CW_NOP;
         rs_e <= 5'd0;
         rt_e <= 5'd0;
      end else begin
         if (stall) begin
            cw_e <= CW_NOP;
            rs_e <= 5'd0;
            rt_e <= 5'd0;
         end else begin
            cw_e <= age(cw_d);
            rs_e <= rs;
            rt_e <= rt;
         end
         cw_m <= age(cw_e);
         cw_w <= age(cw_m);
      end
   end

   // A new start has priority over the final decrement of the previous op.
   always_ff @(posedge clk) begin
      if (!reset_n)                    md_count <= 5'd0;
      else if (cw_e.md_op == MD_MULT)  md_count <= MULT_LOAD;
      else if (cw_e.md_op == MD_DIV)   md_count <= DIV_LOAD;
      else if (md_count != 5'd0)       md_count <= md_count - 5'd1;
   end

   assign md_busy     = (md_count != 5'd0);
   assign md_start_e  = cw_e.md_op;
   assign alu_op_e    = cw_e.alu_op;
   assign alu_b_sel_e = cw_e.alu_b_sel;
   assign dm_we_m     = cw_m.dm_we;
   assign dm_re_m     = cw_m.dm_re;
   assign reg_we_w    = cw_w.reg_we;
   assign wa_w        = cw_w.wa;
   assign wd_sel_w    = cw_w.wd_sel;

endmodule
